wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_sequencer.sv | 100 ++++++++++
 tb/tb_wide_add_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-cycle W-bit adder/subtractor that ripples one S-bit slice per clock.
// The operands are latched on accept, and the result is held in DONE until the consumer takes it.
module wide_add_sequencer #(
    parameter int W = 32,
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);
    localparam int N  = W / S;
    localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);

    if ((W % S) != 0 || (W / S) < 2) begin : g_bad_params
        $error("wide_add_sequencer: W must be a multiple of S with W/S >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic [CW-1:0] k_q;
    logic          carry_q, cout_q, ovf_q;

    logic [S-1:0]  a_sl, b_sl;
    logic [S:0]    slice_d;
    logic          last_slice, cin_msb;

    assign a_sl       = a_q[k_q*S +: S];
    assign b_sl       = b_q[k_q*S +: S];
    assign slice_d    = {1'b0, a_sl} + {1'b0, b_sl} + {{S{1'b0}}, carry_q};
    assign last_slice = (k_q == CW'(N - 1));
    // The carry into the MSB is recovered from the sum bit: s = a ^ b ^ cin.
    assign cin_msb    = a_sl[S-1] ^ b_sl[S-1] ^ slice_d[S-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        // Subtraction is A + ~B + 1, so the +1 enters as the initial carry.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        k_q     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[k_q*S +: S] <= slice_d[S-1:0];
                    carry_q           <= slice_d[S];
                    if (last_slice) begin
                        cout_q  <= slice_d[S];
                        ovf_q   <= cin_msb ^ slice_d[S];
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = (sum_q == '0);
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed corner cases, hold/ignore,
// reset abort and a randomized back-to-back regression against an arithmetic model.
module tb_wide_add_sequencer;
    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out, overflow, zero;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.W(W), .S(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    // Plain W-bit arithmetic: carry is the unsigned wrap for add, not-borrow (a >= b) for sub.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        res_t       r;
        logic [W:0] t;
        if (!op) begin
            t   = {1'b0, x} + {1'b0, y};
            r.s = t[W-1:0];
            r.c = t[W];
            r.v = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        end else begin
            r.s = x - y;
            r.c = (x >= y);
            r.v = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
        end
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and count edges (accept edge included) until out_valid shows.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        a = x; b = y; sub = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        vecs++;
        if ({in_ready, out_valid, sum, carry_out, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h c=%b v=%b z=%b, want rdy=1 vld=0 sum=0 c=0 v=0 z=1",
                     in_ready, out_valid, sum, carry_out, overflow, zero);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'd3, 32'd0};
        logic [W-1:0] tb [7] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd5, 32'd4, 32'd1};
        logic         top[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        res_t         texp[7] = '{
            '{32'h0000_0100, 1'b0, 1'b0, 1'b0},
            '{32'h0000_0000, 1'b1, 1'b0, 1'b1},
            '{32'h8000_0000, 1'b0, 1'b1, 1'b0},
            '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
            '{32'h0000_0000, 1'b1, 1'b0, 1'b1},
            '{32'h0000_0007, 1'b0, 1'b0, 1'b0},
            '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        int lat;
        for (int i = 0; i < 7; i++) begin
            launch(ta[i], tb[i], top[i], lat);
            vecs++;
            if (lat !== N + 1) begin
                errs++;
                $display("FAIL latency[%0d]: got %0d edges, want %0d", i, lat, N + 1);
            end
            vecs++;
            if ({sum, carry_out, overflow, zero} !== texp[i]) begin
                errs++;
                $display("FAIL directed[%0d]: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                         i, sum, carry_out, overflow, zero, texp[i].s, texp[i].c, texp[i].v, texp[i].z);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            vecs++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errs++;
                $display("FAIL consume[%0d]: got vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        launch(32'd5, 32'd5, 1'b1, lat);
        for (int i = 0; i < 3; i++) begin
            a = 32'd1; b = 32'd1; sub = 1'b0; in_valid = 1'b1;
            tick();
            vecs++;
            if ({out_valid, in_ready, sum, carry_out, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1}) begin
                errs++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%h c=%b v=%b z=%b, want vld=1 rdy=0 sum=0 c=1 v=0 z=1",
                         i, out_valid, in_ready, sum, carry_out, overflow, zero);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick(); tick();
        vecs++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errs++;
            $display("FAIL hold_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int  lat;
        logic seen;
        a = 32'h1234_5678; b = 32'h0FED_CBA9; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vecs++;
        if ({in_ready, out_valid, sum, carry_out, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL abort_state: got rdy=%b vld=%b sum=%h c=%b v=%b z=%b, want rdy=1 vld=0 sum=0 c=0 v=0 z=1",
                     in_ready, out_valid, sum, carry_out, overflow, zero);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL abort_no_result: got out_valid pulse=%b, want 0", seen);
        end
        launch(32'd3, 32'd4, 1'b0, lat);
        vecs++;
        if ({lat == N + 1, sum, carry_out, overflow, zero} !== {1'b1, 32'd7, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL abort_next_op: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=%0d sum=7 c=0 v=0 z=0",
                     lat, sum, carry_out, overflow, zero, N + 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e;
        int   got, cyc, last;
        got = 0; cyc = 0; last = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        while (got < 1000 && cyc < 8000) begin
            // Operands on the bus while in_ready is high get taken at the coming edge.
            if (in_ready) q.push_back(model(a, b, sub));
            tick();
            cyc++;
            if (out_valid) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL b2b_spurious: got result sum=%h with no operation pending, want none", sum);
                end else begin
                    e = q.pop_front();
                    if ({sum, carry_out, overflow, zero} !== e) begin
                        errs++;
                        $display("FAIL b2b[%0d]: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                                 got, sum, carry_out, overflow, zero, e.s, e.c, e.v, e.z);
                    end
                end
                if (last >= 0) begin
                    vecs++;
                    if (cyc - last != N + 2) begin
                        errs++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", got, cyc - last, N + 2);
                    end
                end
                last = cyc;
                got++;
            end
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        end
        vecs++;
        if (got < 1000) begin
            errs++;
            $display("FAIL b2b_timeout: got %0d results, want 1000", got);
        end
        in_valid = 1'b0;
        for (int i = 0; i < N + 3; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
